alu_ctrl: RTL and testbench

Issue controller and flag owner for the 16-bit ALU datapath. Accepts one ALU operation at a time through a valid/ready request port. Sequences shift and rotate operations as an iterative one-bit-per-cycle loop. Returns each result through a valid/ready response port, and holds the architectural N/Z/V flag register, updating it per opcode. It sits between decode and writeback in the processor datapath.

---
 rtl/alu_pkg.sv | 43 ++++
 rtl/alu_ctrl_if.sv | 25 ++
 rtl/alu_shift_step.sv | 17 +
 rtl/alu_ctrl.sv | 169 ++++++++++++++++
 tb/tb_alu_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: ISA opcodes, controller states,
// saturation limits and the per-opcode N/Z/V write-enable mask.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'h0,
    OP_SUB    = 4'h1,
    OP_XOR    = 4'h2,
    OP_RED    = 4'h3,
    OP_SLL    = 4'h4,
    OP_SRA    = 4'h5,
    OP_ROR    = 4'h6,
    OP_PADDSB = 4'h7,
    OP_LW     = 4'h8,
    OP_SW     = 4'h9,
    OP_LLB    = 4'hA,
    OP_LHB    = 4'hB,
    OP_B      = 4'hC,
    OP_BR     = 4'hD,
    OP_PCS    = 4'hE,
    OP_HLT    = 4'hF
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [15:0] SAT_POS = 16'h7FFF;
  localparam logic [15:0] SAT_NEG = 16'h8000;

  // Bit order of the mask is {N, Z, V}.
  function automatic logic [2:0] flag_we(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB:         flag_we = 3'b111;
      OP_XOR, OP_SLL,
      OP_SRA, OP_ROR:         flag_we = 3'b010;
      default:                flag_we = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/alu_ctrl_if.sv
// Request/response bundle between decode (master) and the ALU controller (slave),
// including the architectural flag outputs.
interface alu_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        N_Flag;
  logic        Z_Flag;
  logic        V_Flag;

  modport master (
    output req_valid, req_op, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_data, N_Flag, Z_Flag, V_Flag
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, res_ready,
    output req_ready, res_valid, res_data, N_Flag, Z_Flag, V_Flag
  );
endinterface

// File: rtl/alu_shift_step.sv
// One-bit shift/rotate step: op[1:0] selects SLL (00), SRA (01) or ROR (10); 11 passes through.
module alu_shift_step (
  input  logic [1:0]  op,
  input  logic [15:0] din,
  output logic [15:0] dout
);

  always_comb begin
    case (op)
      2'b00:   dout = {din[14:0], 1'b0};
      2'b01:   dout = {din[15], din[15:1]};
      2'b10:   dout = {din[0], din[15:1]};
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/alu_ctrl.sv
// ALU issue controller: accepts one op, sequences shifts one bit per cycle, owns N/Z/V.
// Build option ALU_CTRL_FAST_SHIFT_EN swaps the shift loop for a single-cycle barrel shifter.
module alu_ctrl
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  alu_ctrl_if.slave  bus
);

  state_t      state_q, state_d;
  logic [15:0] res_q, res_d;
  logic        n_q, n_d, z_q, z_d, v_q, v_d;

  logic [15:0] sum, diff, idle_res, shifted, fin_res;
  logic [3:0]  amt, fin_op;
  logic [2:0]  we;
  logic        add_ovf, sub_ovf, idle_v, fin_v, fin_en;

  assign amt = bus.req_b[3:0];

`ifdef ALU_CTRL_FAST_SHIFT_EN
  logic [15:0] stage [16];
  genvar gi;

  assign stage[0] = bus.req_a;
  generate
    for (gi = 0; gi < 15; gi++) begin : g_barrel
      alu_shift_step u_step (
        .op   (bus.req_op[1:0]),
        .din  (stage[gi]),
        .dout (stage[gi+1])
      );
    end
  endgenerate
  assign shifted = stage[amt];
`else
  logic [3:0]  cnt_q, cnt_d, op_q, op_d;
  logic [15:0] step_in, step_out;
  logic [1:0]  step_sel;
  logic        is_shift;

  // The single step unit performs the first step on the accept cycle, then iterates on res_q.
  assign step_in  = (state_q == IDLE) ? bus.req_a : res_q;
  assign step_sel = (state_q == IDLE) ? bus.req_op[1:0] : op_q[1:0];
  assign is_shift = (bus.req_op == OP_SLL) || (bus.req_op == OP_SRA) || (bus.req_op == OP_ROR);

  alu_shift_step u_step (
    .op   (step_sel),
    .din  (step_in),
    .dout (step_out)
  );
  assign shifted = (amt == 4'd0) ? bus.req_a : step_out;
`endif

  always_comb begin
    sum      = bus.req_a + bus.req_b;
    diff     = bus.req_a - bus.req_b;
    add_ovf  = (bus.req_a[15] == bus.req_b[15]) && (sum[15] != bus.req_a[15]);
    sub_ovf  = (bus.req_a[15] != bus.req_b[15]) && (diff[15] != bus.req_a[15]);
    idle_v   = 1'b0;
    idle_res = bus.req_a;
    // On overflow the sign of operand a tells which rail was crossed.
    case (bus.req_op)
      OP_ADD: begin
        idle_v   = add_ovf;
        idle_res = add_ovf ? (bus.req_a[15] ? SAT_NEG : SAT_POS) : sum;
      end
      OP_SUB: begin
        idle_v   = sub_ovf;
        idle_res = sub_ovf ? (bus.req_a[15] ? SAT_NEG : SAT_POS) : diff;
      end
      OP_XOR:                 idle_res = bus.req_a ^ bus.req_b;
      OP_LLB:                 idle_res = {bus.req_a[15:8], bus.req_b[7:0]};
      OP_LHB:                 idle_res = {bus.req_b[7:0], bus.req_a[7:0]};
      OP_SLL, OP_SRA, OP_ROR: idle_res = shifted;
      default:                idle_res = bus.req_a;
    endcase
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    fin_en  = 1'b0;
    fin_res = idle_res;
    fin_op  = bus.req_op;
    fin_v   = idle_v;
`ifndef ALU_CTRL_FAST_SHIFT_EN
    cnt_d   = cnt_q;
    op_d    = op_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          res_d = idle_res;
`ifndef ALU_CTRL_FAST_SHIFT_EN
          op_d  = bus.req_op;
          if (is_shift && (amt > 4'd1)) begin
            state_d = SHIFT;
            cnt_d   = amt - 4'd1;
          end else begin
            state_d = DONE;
            fin_en  = 1'b1;
          end
`else
          state_d = DONE;
          fin_en  = 1'b1;
`endif
        end
      end
      SHIFT: begin
`ifndef ALU_CTRL_FAST_SHIFT_EN
        res_d   = step_out;
        cnt_d   = cnt_q - 4'd1;
        fin_res = step_out;
        fin_op  = op_q;
        fin_v   = 1'b0;
        if (cnt_q == 4'd1) begin
          state_d = DONE;
          fin_en  = 1'b1;
        end
`else
        state_d = IDLE;
`endif
      end
      DONE: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    we  = flag_we(fin_op);
    n_d = (fin_en && we[2]) ? fin_res[15] : n_q;
    z_d = (fin_en && we[1]) ? (fin_res == 16'h0000) : z_q;
    v_d = (fin_en && we[0]) ? fin_v : v_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      res_q   <= 16'h0000;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      v_q     <= 1'b0;
`ifndef ALU_CTRL_FAST_SHIFT_EN
      cnt_q   <= 4'd0;
      op_q    <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      n_q     <= n_d;
      z_q     <= z_d;
      v_q     <= v_d;
`ifndef ALU_CTRL_FAST_SHIFT_EN
      cnt_q   <= cnt_d;
      op_q    <= op_d;
`endif
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.res_valid = (state_q == DONE);
  assign bus.res_data  = res_q;
  assign bus.N_Flag    = n_q;
  assign bus.Z_Flag    = z_q;
  assign bus.V_Flag    = v_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: directed cases plus randomized ops against a
// behavioural model of results, flags and latency.
module tb_alu_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic m_n, m_z, m_v;

  alu_ctrl_if bus ();

  alu_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference result from plain integer arithmetic.
  function automatic logic [15:0] ref_result(input logic [3:0] op, input logic [15:0] a,
                                             input logic [15:0] b, output logic ovf);
    int s;
    int k;
    k   = int'(b[3:0]);
    ovf = 1'b0;
    case (op)
      4'h0, 4'h1: begin
        if (op == 4'h0) s = int'($signed(a)) + int'($signed(b));
        else            s = int'($signed(a)) - int'($signed(b));
        if (s > 32767) begin
          ovf = 1'b1;
          return 16'h7FFF;
        end
        if (s < -32768) begin
          ovf = 1'b1;
          return 16'h8000;
        end
        return s[15:0];
      end
      4'h2: return a ^ b;
      4'h4: return a << k;
      4'h5: return $signed(a) >>> k;
      4'h6: return (k == 0) ? a : ((a >> k) | (a << (16 - k)));
      4'hA: return {a[15:8], b[7:0]};
      4'hB: return {b[7:0], a[7:0]};
      default: return a;
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] op, input logic [15:0] b);
`ifdef ALU_CTRL_FAST_SHIFT_EN
    return 1;
`else
    if ((op == 4'h4 || op == 4'h5 || op == 4'h6) && b[3:0] != 4'd0) return int'(b[3:0]);
    return 1;
`endif
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input int hold);
    logic [15:0] exp_res;
    logic        ovf;
    int          exp_lat;
    int          lat;
    exp_res = ref_result(op, a, b, ovf);
    exp_lat = ref_latency(op, b);
    if (op == 4'h0 || op == 4'h1) begin
      m_n = exp_res[15];
      m_z = (exp_res == 16'h0000);
      m_v = ovf;
    end else if (op == 4'h2 || op == 4'h4 || op == 4'h5 || op == 4'h6) begin
      m_z = (exp_res == 16'h0000);
    end

    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_before_req: req_ready=%b want 1", bus.req_ready);
    end
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (bus.res_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat != exp_lat) begin
      n_fail++;
      $display("FAIL latency op=%h: got %0d want %0d", op, lat, exp_lat);
    end
    n_checks++;
    if (bus.res_data !== exp_res) begin
      n_fail++;
      $display("FAIL result op=%h a=%h b=%h: got %h want %h", op, a, b, bus.res_data, exp_res);
    end
    n_checks++;
    if ({bus.N_Flag, bus.Z_Flag, bus.V_Flag} !== {m_n, m_z, m_v}) begin
      n_fail++;
      $display("FAIL flags op=%h: got nzv=%b want %b", op,
               {bus.N_Flag, bus.Z_Flag, bus.V_Flag}, {m_n, m_z, m_v});
    end

    // Backpressure: offer junk requests while the result is held.
    for (int i = 0; i < hold; i++) begin
      bus.req_valid = 1'b1;
      bus.req_op    = 4'($urandom_range(0, 15));
      bus.req_a     = 16'($urandom);
      bus.req_b     = 16'($urandom);
      @(negedge clk);
      n_checks++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== exp_res || bus.req_ready !== 1'b0 ||
          {bus.N_Flag, bus.Z_Flag, bus.V_Flag} !== {m_n, m_z, m_v}) begin
        n_fail++;
        $display("FAIL hold cycle %0d: valid=%b data=%h ready=%b nzv=%b want 1 %h 0 %b", i,
                 bus.res_valid, bus.res_data, bus.req_ready,
                 {bus.N_Flag, bus.Z_Flag, bus.V_Flag}, exp_res, {m_n, m_z, m_v});
      end
    end
    bus.req_valid = 1'b0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    n_checks++;
    if (bus.res_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL after_handshake: valid=%b ready=%b want 0 1", bus.res_valid, bus.req_ready);
    end
    $display("txn op=%h a=%h b=%h res=%h lat=%0d hold=%0d nzv=%b", op, a, b, bus.res_data,
             lat, hold, {bus.N_Flag, bus.Z_Flag, bus.V_Flag});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_n = 1'b0;
    m_z = 1'b0;
    m_v = 1'b0;
    n_checks++;
    if (bus.req_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.res_data !== 16'h0000 ||
        {bus.N_Flag, bus.Z_Flag, bus.V_Flag} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b valid=%b data=%h nzv=%b want 1 0 0000 000",
               bus.req_ready, bus.res_valid, bus.res_data, {bus.N_Flag, bus.Z_Flag, bus.V_Flag});
    end
    $display("txn reset");
  endtask

  task automatic test_arith();
    run_op(4'h0, 16'h7FFF, 16'h0001, 0);
    run_op(4'h1, 16'h0005, 16'h0005, 0);
    run_op(4'h2, 16'h00FF, 16'h0F0F, 0);
    run_op(4'h0, 16'h8000, 16'hFFFF, 0);
    run_op(4'h1, 16'h8000, 16'h0001, 1);
    run_op(4'h1, 16'h7FFF, 16'hFFFF, 0);
    run_op(4'h0, 16'h1234, 16'h0F0F, 0);
  endtask

  task automatic test_shift();
    run_op(4'h5, 16'h8000, 16'h000F, 0);
    run_op(4'h6, 16'h0001, 16'h0001, 0);
    run_op(4'h4, 16'h1234, 16'h0000, 0);
    run_op(4'h4, 16'h8001, 16'h0001, 0);
    run_op(4'h6, 16'h00F1, 16'h0004, 0);
    run_op(4'h4, 16'hFFFF, 16'h000F, 0);
  endtask

  task automatic test_backpressure();
    run_op(4'hA, 16'hAB00, 16'h00CD, 5);
    run_op(4'hB, 16'h1234, 16'h5678, 3);
  endtask

  task automatic test_reset_mid_shift();
    run_op(4'h1, 16'h0042, 16'h0042, 0);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 4'h4;
    bus.req_a     = 16'h00FF;
    bus.req_b     = 16'h0008;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
`ifndef ALU_CTRL_FAST_SHIFT_EN
    n_checks++;
    if (bus.res_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_shift_busy: valid=%b ready=%b want 0 0", bus.res_valid, bus.req_ready);
    end
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_n = 1'b0;
    m_z = 1'b0;
    m_v = 1'b0;
    n_checks++;
    if (bus.req_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.res_data !== 16'h0000 ||
        {bus.N_Flag, bus.Z_Flag, bus.V_Flag} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_mid_shift: ready=%b valid=%b data=%h nzv=%b want 1 0 0000 000",
               bus.req_ready, bus.res_valid, bus.res_data, {bus.N_Flag, bus.Z_Flag, bus.V_Flag});
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.res_valid !== 1'b0 || bus.Z_Flag !== 1'b0) begin
        n_fail++;
        $display("FAIL abandoned_op cycle %0d: valid=%b z=%b want 0 0", i, bus.res_valid,
                 bus.Z_Flag);
      end
    end
    $display("txn reset_mid_shift");
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_d;
    logic        drove_idle;
    int          accepted;
    @(negedge clk);
    bus.res_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_op    = 4'h2;
    bus.req_a     = 16'($urandom);
    bus.req_b     = 16'($urandom);
    exp_d         = bus.req_a ^ bus.req_b;
    drove_idle    = 1'b1;
    accepted      = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (drove_idle) begin
        m_z = (exp_d == 16'h0000);
        n_checks++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== exp_d || bus.Z_Flag !== m_z) begin
          n_fail++;
          $display("FAIL b2b_result cycle %0d: valid=%b data=%h z=%b want 1 %h %b", i,
                   bus.res_valid, bus.res_data, bus.Z_Flag, exp_d, m_z);
        end
        $display("txn b2b xor res=%h", bus.res_data);
        accepted++;
        drove_idle = 1'b0;
      end else begin
        n_checks++;
        if (bus.res_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_gap cycle %0d: valid=%b ready=%b want 0 1", i, bus.res_valid,
                   bus.req_ready);
        end
        drove_idle = 1'b1;
      end
      bus.req_a = 16'($urandom);
      bus.req_b = 16'($urandom);
      if (drove_idle) exp_d = bus.req_a ^ bus.req_b;
    end
    bus.req_valid = 1'b0;
    bus.res_ready = 1'b0;
    n_checks++;
    if (accepted != 5) begin
      n_fail++;
      $display("FAIL b2b_throughput: got %0d ops want 5", accepted);
    end
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [15:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = 16'($urandom);
      b  = 16'($urandom);
      if (i % 4 == 0) op = 4'($urandom_range(4, 6));
      run_op(op, a, b, int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = 4'h0;
    bus.req_a     = 16'h0000;
    bus.req_b     = 16'h0000;
    bus.res_ready = 1'b0;
    test_reset();
    test_arith();
    test_shift();
    test_backpressure();
    test_reset_mid_shift();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
